fifo_arbiter: RTL and testbench

- Controller that shares one single-port-per-cycle 8-bit FIFO between NUM_REQ writers and one consumer.
- Round-robin arbitration between writers; write/read phases alternate with a bounded burst length.
- Flush command drains the FIFO; a registered output stage presents read data to the consumer with valid/ready.
- Never asserts FIFO read and write together, and keeps its own occupancy count so the FIFO never exceeds 2^ADDR_W-1 entries.

---
 rtl/fifo_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fifo_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: shares one 8-bit FIFO between NUM_REQ writers and one consumer.
// Writers are served round-robin. Write and read phases alternate, and a phase
// yields after BURST ops when the other side is waiting. A flush pulse drains
// the FIFO. Read data is presented through a registered valid/ready stage.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   req_valid/req_data         per-writer byte offers (byte i at [8i+7:8i])
//   req_ready                  one-hot accept strobe (combinational)
//   flush                      one-cycle request to discard FIFO contents
//   fifo_din/fifo_we/fifo_re   FIFO write data and strobes (combinational)
//   fifo_dout                  FIFO show-ahead head word
//   out_valid/out_data         registered consumer output
//   out_ready                  consumer accept
//   occupancy                  registered FIFO entry count
//   busy                       controller is not idle
module fifo_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned BURST   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   flush,
    output logic [7:0]             fifo_din,
    output logic                   fifo_we,
    output logic                   fifo_re,
    input  logic [7:0]             fifo_dout,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic [ADDR_W:0]        occupancy,
    output logic                   busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned BC_W  = 5;
    localparam logic [CNT_W-1:0] CAP     = CNT_W'((64'd1 << ADDR_W) - 64'd1);
    localparam logic [BC_W-1:0]  BURST_C = BC_W'(BURST);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] occ_nx;
    logic [PTR_W-1:0] rr_ptr, rr_nx;
    logic [BC_W-1:0]  burst_cnt, bc_nx;
    logic             last_wr, last_wr_nx;
    logic             ov_nx;
    logic [7:0]       od_nx;

    logic             want_wr, want_rd, burst_end, flush_hit;
    logic [PTR_W-1:0] grant_idx, up_idx, any_idx, grant_nx;
    logic             up_hit;
    logic [7:0]       grant_data;
    logic [NUM_REQ-1:0] grant_onehot;

    assign want_wr   = (|req_valid) && (occupancy < CAP);
    assign want_rd   = (occupancy != '0) && (!out_valid || out_ready);
    assign burst_end = (burst_cnt + BC_W'(1)) >= BURST_C;
    assign flush_hit = flush && (state != FLUSH);
    assign busy      = (state != IDLE);

    // Round-robin pick: lowest valid index at/above rr_ptr, else lowest valid overall.
    always_comb begin
        up_hit       = 1'b0;
        up_idx       = '0;
        any_idx      = '0;
        grant_data   = '0;
        grant_onehot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_idx = PTR_W'(i);
                if (i >= int'(rr_ptr)) begin
                    up_hit = 1'b1;
                    up_idx = PTR_W'(i);
                end
            end
        end
        grant_idx = up_hit ? up_idx : any_idx;
        grant_nx  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == grant_idx) begin
                grant_data      = req_data[8*i +: 8];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // Phase control, FIFO strobes and output-stage next values.
    always_comb begin
        state_nx   = state;
        occ_nx     = occupancy;
        rr_nx      = rr_ptr;
        bc_nx      = burst_cnt;
        last_wr_nx = last_wr;
        ov_nx      = out_valid;
        od_nx      = out_data;
        req_ready  = '0;
        fifo_we    = 1'b0;
        fifo_re    = 1'b0;
        fifo_din   = '0;

        if (out_valid && out_ready) ov_nx = 1'b0;

        if (flush_hit) begin
            state_nx = FLUSH;
            ov_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (want_wr && want_rd) state_nx = last_wr ? READ : WRITE;
                    else if (want_wr)       state_nx = WRITE;
                    else if (want_rd)       state_nx = READ;
                end
                WRITE: begin
                    if (want_wr) begin
                        fifo_we    = 1'b1;
                        fifo_din   = grant_data;
                        req_ready  = grant_onehot;
                        occ_nx     = occupancy + CNT_W'(1);
                        rr_nx      = grant_nx;
                        last_wr_nx = 1'b1;
                        bc_nx      = (burst_cnt >= BURST_C) ? burst_cnt : burst_cnt + BC_W'(1);
                    end
                    if (!want_wr)                   state_nx = want_rd ? READ : IDLE;
                    else if (burst_end && want_rd)  state_nx = READ;
                end
                READ: begin
                    if (want_rd) begin
                        fifo_re    = 1'b1;
                        occ_nx     = occupancy - CNT_W'(1);
                        ov_nx      = 1'b1;
                        od_nx      = fifo_dout;
                        last_wr_nx = 1'b0;
                        bc_nx      = (burst_cnt >= BURST_C) ? burst_cnt : burst_cnt + BC_W'(1);
                    end
                    if (!want_rd)                   state_nx = want_wr ? WRITE : IDLE;
                    else if (burst_end && want_wr)  state_nx = WRITE;
                end
                default: begin
                    // Drain: pops are discarded, the consumer sees nothing.
                    ov_nx = 1'b0;
                    if (occupancy != '0) begin
                        fifo_re = 1'b1;
                        occ_nx  = occupancy - CNT_W'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
            endcase
        end

        // A fresh phase always starts with a full burst allowance.
        if (state_nx != state) bc_nx = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            occupancy <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            last_wr   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            occupancy <= occ_nx;
            rr_ptr    <= rr_nx;
            burst_cnt <= bc_nx;
            last_wr   <= last_wr_nx;
            out_valid <= ov_nx;
            out_data  <= od_nx;
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: models the FIFO memory, drives writers and consumer,
// and compares every cycle against a behavioural reference model.
module tb_fifo_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 3;
    localparam int BU  = 4;
    localparam int CAP = (1 << AW) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              flush;
    logic [7:0]        fifo_din;
    logic              fifo_we;
    logic              fifo_re;
    logic [7:0]        fifo_dout = 8'h00;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic [AW:0]       occupancy;
    logic              busy;

    fifo_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .BURST(BU)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .flush(flush),
        .fifo_din(fifo_din), .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_dout(fifo_dout),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO memory seen by the DUT: show-ahead head word.
    logic [7:0] envq[$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            envq.delete();
            fifo_dout <= 8'h00;
        end else begin
            if (fifo_we) envq.push_back(fifo_din);
            if (fifo_re && envq.size() > 0) void'(envq.pop_front());
            fifo_dout <= (envq.size() > 0) ? envq[0] : 8'h00;
        end
    end

    // Reference model: phase 0 idle, 1 writing, 2 reading, 3 draining.
    int         m_ph, m_occ, m_rr, m_run;
    bit         m_last_wr, m_ov;
    logic [7:0] m_od;
    logic [7:0] mq[$];

    bit         log_on = 1'b0;
    logic [7:0] dinlog[$];
    bit         opslog[$];
    int         re_cnt = 0;

    always @(negedge clk) begin : model
        int g, j, nph;
        bit ww, wr, fh, rd_out, e_we, e_re;
        logic [NR-1:0] e_rdy;
        logic [7:0] e_din;
        if (!reset) begin
            m_ph = 0; m_occ = 0; m_rr = 0; m_run = 0;
            m_last_wr = 1'b0; m_ov = 1'b0; m_od = 8'h00;
            mq.delete();
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_we_re", {30'd0, fifo_we, fifo_re}, 32'd0);
            chk("rst_out", {23'd0, out_valid, out_data}, 32'd0);
            chk("rst_occ_busy", {27'd0, occupancy, busy}, 32'd0);
        end else begin
            e_we = 0; e_re = 0; e_rdy = '0; e_din = 8'h00; g = 0; rd_out = 0;
            ww  = (req_valid != '0) && (m_occ < CAP);
            wr  = (m_occ > 0) && (!m_ov || out_ready);
            fh  = flush && (m_ph != 3);
            nph = m_ph;
            if (fh) nph = 3;
            else case (m_ph)
                0: begin
                    if (ww && wr)  nph = m_last_wr ? 2 : 1;
                    else if (ww)   nph = 1;
                    else if (wr)   nph = 2;
                end
                1: begin
                    if (ww) begin
                        for (int k = 0; k < NR; k++) begin
                            j = (m_rr + k) % NR;
                            if (req_valid[j]) begin g = j; break; end
                        end
                        e_we = 1; e_din = req_data[8*g +: 8]; e_rdy[g] = 1'b1;
                    end
                    if (!ww)                          nph = wr ? 2 : 0;
                    else if (m_run + 1 >= BU && wr)   nph = 2;
                end
                2: begin
                    if (wr) begin e_re = 1; rd_out = 1; end
                    if (!wr)                          nph = ww ? 1 : 0;
                    else if (m_run + 1 >= BU && ww)   nph = 1;
                end
                default: begin
                    if (m_occ > 0) e_re = 1;
                    else nph = 0;
                end
            endcase

            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("fifo_we", 32'(fifo_we), 32'(e_we));
            chk("fifo_re", 32'(fifo_re), 32'(e_re));
            chk("fifo_din", 32'(fifo_din), 32'(e_din));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("occupancy", 32'(occupancy), 32'(m_occ));
            chk("busy", 32'(busy), 32'(m_ph != 0));

            if (e_we) begin
                mq.push_back(e_din);
                m_occ++;
                m_rr = (g + 1) % NR;
                m_last_wr = 1'b1;
            end
            if (e_re) begin
                if (rd_out) begin m_od = mq[0]; m_last_wr = 1'b0; end
                void'(mq.pop_front());
                m_occ--;
            end
            if (rd_out)                    m_ov = 1'b1;
            else if (fh || m_ph == 3)      m_ov = 1'b0;
            else if (m_ov && out_ready)    m_ov = 1'b0;
            if (nph != m_ph)               m_run = 0;
            else if (e_we || e_re)         m_run++;
            m_ph = nph;
        end
        if (log_on) begin
            if (fifo_we) dinlog.push_back(fifo_din);
            if (fifo_we || fifo_re) opslog.push_back(fifo_we);
        end
        if (fifo_re) re_cnt++;
    end

    // Writers: mode 0 no new offers, 1 continuous on mask with fresh bytes,
    // 2 random, 3 constant byte 0x10+i on mask.
    int         mode = 0;
    logic [NR-1:0] mask = '0;
    bit         wv[NR];
    logic [7:0] wd[NR];
    logic [7:0] seq = 8'h40;

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = wv[i];
            req_data[8*i +: 8]  = wd[i];
        end
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        #1 acc = req_ready;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) wv[i] = 1'b0;
            if (!wv[i]) begin
                if (mode == 1 && mask[i]) begin
                    wv[i] = 1'b1; wd[i] = seq; seq = seq + 8'd1;
                end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    wv[i] = 1'b1; wd[i] = 8'($urandom);
                end else if (mode == 3 && mask[i]) begin
                    wv[i] = 1'b1; wd[i] = 8'(8'h10 + i);
                end
            end
        end
        apply();
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] pat;
        bit done;
        for (int i = 0; i < NR; i++) begin wv[i] = 1'b0; wd[i] = 8'h00; end
        flush = 1'b0; out_ready = 1'b0;
        apply();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Idle with no requests.
        for (int c = 0; c < 5; c++) begin step(); chk("idle_busy", 32'(busy), 32'd0); end

        // Round robin with constant bytes and a stalled consumer, then fill to capacity.
        re_cnt = 0; log_on = 1'b1; dinlog.delete();
        mode = 3; mask = 4'b1111;
        repeat (25) step();
        chk("rr_len_ok", 32'(dinlog.size() >= 5), 32'd1);
        if (dinlog.size() >= 5) begin
            chk("rr_g0", 32'(dinlog[0]), 32'h10);
            chk("rr_g1", 32'(dinlog[1]), 32'h11);
            chk("rr_g2", 32'(dinlog[2]), 32'h12);
            chk("rr_g3", 32'(dinlog[3]), 32'h13);
            chk("rr_g4", 32'(dinlog[4]), 32'h10);
        end
        chk("full_writes", 32'(dinlog.size()), 32'd8);
        chk("full_occ", 32'(occupancy), 32'(CAP));
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_reads", 32'(re_cnt), 32'd1);

        // Backpressure: head byte held.
        for (int c = 0; c < 6; c++) begin
            step();
            chk("bp_data", 32'(out_data), 32'h10);
            chk("bp_no_re", 32'(fifo_re), 32'd0);
        end

        // Flush a full FIFO.
        mode = 0; re_cnt = 0;
        flush = 1'b1;
        step();
        chk("flush_ov", 32'(out_valid), 32'd0);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (!busy) done = 1'b1;
        end
        chk("flush_done", 32'(done), 32'd1);
        chk("flush_reads", 32'(re_cnt), 32'(CAP));
        chk("flush_occ", 32'(occupancy), 32'd0);

        // Drain held writers.
        out_ready = 1'b1;
        repeat (30) step();
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);

        // Burst alternation with three continuous writers.
        opslog.delete();
        mode = 1; mask = 4'b0111;
        repeat (30) step();
        pat = 16'h0000;
        for (int k = 0; k < 16 && k < opslog.size(); k++) pat[15-k] = opslog[k];
        chk("burst_pattern", 32'(pat), 32'h0000F0F0);
        log_on = 1'b0;

        // Randomized traffic with occasional flush.
        mode = 2;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) flush = 1'b1;
            step();
        end

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_strobes", {30'd0, fifo_we, fifo_re}, 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        mode = 0;
        for (int i = 0; i < NR; i++) wv[i] = 1'b0;
        apply();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin step(); chk("post_rst_busy", 32'(busy), 32'd0); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
